// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: register address type,
// controller state encodings and the stall/flush control bundle.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int CTR_STALL_W = 16;
    localparam int WAIT_CNT_W  = 8;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_HALT     = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic stall_pc;
        logic stall_ifid;
        logic stall_idexe;
        logic stall_exemem;
        logic flush_ifid;
        logic flush_idexe;
        logic flush_memwb;
        logic halted;
    } hz_ctrl_t;

    localparam int HZ_CTRL_W = $bits(hz_ctrl_t);

    // Freeze every stage and drop a bubble into MEM_WB; used by both the
    // memory-wait and halt cases.
    function automatic hz_ctrl_t ctrl_freeze(input logic halt);
        hz_ctrl_t c;
        c              = '0;
        c.stall_pc     = 1'b1;
        c.stall_ifid   = 1'b1;
        c.stall_idexe  = 1'b1;
        c.stall_exemem = 1'b1;
        c.flush_memwb  = 1'b1;
        c.halted       = halt;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: the load in EXE writes a register the
// instruction in ID is about to read.
module load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  reg_addr_t rs1_id,
    input  reg_addr_t rs2_id,
    input  logic      useRs1_id,
    input  logic      useRs2_id,
    input  reg_addr_t rd_exe,
    input  logic      registerWriteEnable_exe,
    input  logic      regSelect_exe,
    output logic      lu
);

    logic exe_is_load;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign exe_is_load = regSelect_exe && registerWriteEnable_exe && (rd_exe != '0);
    assign rs1_hit     = useRs1_id && (rs1_id == rd_exe);
    assign rs2_hit     = useRs2_id && (rs2_id == rd_exe);
    assign lu          = exe_is_load && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: load-use, EXE branch flush and multi-cycle
// data-memory waits with a watchdog that halts the pipeline.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  reg_addr_t              rs1_id,
    input  reg_addr_t              rs2_id,
    input  logic                   useRs1_id,
    input  logic                   useRs2_id,
    input  reg_addr_t              rd_exe,
    input  logic                   registerWriteEnable_exe,
    input  logic                   regSelect_exe,
    input  logic                   branchTaken_exe,
    input  logic                   memReq_mem,
    input  logic                   memReady_mem,
    output logic                   stall_pc,
    output logic                   stall_ifid,
    output logic                   stall_idexe,
    output logic                   stall_exemem,
    output logic                   flush_ifid,
    output logic                   flush_idexe,
    output logic                   flush_memwb,
    output logic                   halted,
    output logic [CTR_STALL_W-1:0] stallCycles
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(MEM_TIMEOUT);

    hz_state_t               state;
    hz_state_t               state_next;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic [WAIT_CNT_W-1:0]   wait_next;
    logic [CTR_STALL_W-1:0]  stall_cnt;
    logic                    lu;
    logic                    mw;
    hz_ctrl_t                ctrl;
    hz_ctrl_t                ctrl_out;

    load_use_detect u_load_use_detect (
        .rs1_id                  (rs1_id),
        .rs2_id                  (rs2_id),
        .useRs1_id               (useRs1_id),
        .useRs2_id               (useRs2_id),
        .rd_exe                  (rd_exe),
        .registerWriteEnable_exe (registerWriteEnable_exe),
        .regSelect_exe           (regSelect_exe),
        .lu                      (lu)
    );

    assign mw = memReq_mem && !memReady_mem;

    // Priority mux plus next-state logic. Leaving MEM_WAIT evaluates the
    // cycle as if no wait were pending, so a held branch or load-use is
    // serviced in the release cycle.
    always_comb begin
        ctrl       = '0;
        state_next = state;
        wait_next  = wait_cnt;
        if (state == HZ_HALT) begin
            ctrl = ctrl_freeze(1'b1);
        end else if (mw) begin
            ctrl = ctrl_freeze(1'b0);
            if (state == HZ_RUN) begin
                state_next = HZ_MEM_WAIT;
                wait_next  = WAIT_CNT_W'(1);
            end else if (wait_cnt == TIMEOUT_CNT) begin
                state_next = HZ_HALT;
            end else begin
                wait_next = wait_cnt + WAIT_CNT_W'(1);
            end
        end else begin
            state_next = HZ_RUN;
            wait_next  = '0;
            if (branchTaken_exe) begin
                ctrl.flush_ifid  = 1'b1;
                ctrl.flush_idexe = 1'b1;
            end else if (lu) begin
                ctrl.stall_pc    = 1'b1;
                ctrl.stall_ifid  = 1'b1;
                ctrl.flush_idexe = 1'b1;
            end
        end
    end

    // Gating by reset clears the outputs at once, without waiting for a clock.
    assign ctrl_out = rst ? ctrl : '0;

    assign stall_pc     = ctrl_out.stall_pc;
    assign stall_ifid   = ctrl_out.stall_ifid;
    assign stall_idexe  = ctrl_out.stall_idexe;
    assign stall_exemem = ctrl_out.stall_exemem;
    assign flush_ifid   = ctrl_out.flush_ifid;
    assign flush_idexe  = ctrl_out.flush_idexe;
    assign flush_memwb  = ctrl_out.flush_memwb;
    assign halted       = ctrl_out.halted;
    assign stallCycles  = stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HZ_RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (ctrl_out.stall_pc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CTR_STALL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (watchdog limit set to 4).
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    logic            clk;
    logic            rst;
    reg_addr_t       rs1_id, rs2_id, rd_exe;
    logic            useRs1_id, useRs2_id;
    logic            registerWriteEnable_exe, regSelect_exe;
    logic            branchTaken_exe, memReq_mem, memReady_mem;
    logic            stall_pc, stall_ifid, stall_idexe, stall_exemem;
    logic            flush_ifid, flush_idexe, flush_memwb, halted;
    logic [15:0]     stallCycles;

    int testsRun  = 0;
    int testsFail = 0;

    // Packed as {stall_pc, stall_ifid, stall_idexe, stall_exemem, flush_ifid, flush_idexe, flush_memwb, halted}
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_LU   = 8'b1100_0100;
    localparam logic [7:0] C_BR   = 8'b0000_1100;
    localparam logic [7:0] C_MW   = 8'b1111_0010;
    localparam logic [7:0] C_HALT = 8'b1111_0011;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .rs1_id                  (rs1_id),
        .rs2_id                  (rs2_id),
        .useRs1_id               (useRs1_id),
        .useRs2_id               (useRs2_id),
        .rd_exe                  (rd_exe),
        .registerWriteEnable_exe (registerWriteEnable_exe),
        .regSelect_exe           (regSelect_exe),
        .branchTaken_exe         (branchTaken_exe),
        .memReq_mem              (memReq_mem),
        .memReady_mem            (memReady_mem),
        .stall_pc                (stall_pc),
        .stall_ifid              (stall_ifid),
        .stall_idexe             (stall_idexe),
        .stall_exemem            (stall_exemem),
        .flush_ifid              (flush_ifid),
        .flush_idexe             (flush_idexe),
        .flush_memwb             (flush_memwb),
        .halted                  (halted),
        .stallCycles             (stallCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ctrlVec();
        return {stall_pc, stall_ifid, stall_idexe, stall_exemem,
                flush_ifid, flush_idexe, flush_memwb, halted};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives every input; the load-use style fields are given as (lw, rd, rs1, use1, rs2, use2).
    task automatic applyStimulus(input logic lw, input reg_addr_t rd, input reg_addr_t r1,
                                 input logic u1, input reg_addr_t r2, input logic u2,
                                 input logic br, input logic req, input logic rdy);
        regSelect_exe           = lw;
        registerWriteEnable_exe = lw;
        rd_exe                  = rd;
        rs1_id                  = r1;
        useRs1_id               = u1;
        rs2_id                  = r2;
        useRs2_id               = u2;
        branchTaken_exe         = br;
        memReq_mem              = req;
        memReady_mem            = rdy;
        #3;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_ctrl_gated", 32'(ctrlVec()), 32'(C_NONE));
        stepCycle();
        checkOutput("reset_stallCycles", 32'(stallCycles), 32'd0);
        rst = 1'b1;

        applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rs1", 32'(ctrlVec()), 32'(C_LU));
        stepCycle();
        checkOutput("lu_count", 32'(stallCycles), 32'd1);
        applyIdle();
        checkOutput("lu_clear", 32'(ctrlVec()), 32'(C_NONE));
        stepCycle();

        applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rd0", 32'(ctrlVec()), 32'(C_NONE));
        stepCycle();
        applyStimulus(1'b1, 5'd9, 5'd1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rs2", 32'(ctrlVec()), 32'(C_LU));
        stepCycle();
        applyStimulus(1'b1, 5'd9, 5'd1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rs2_unused", 32'(ctrlVec()), 32'(C_NONE));
        stepCycle();
        checkOutput("lu_rs2_count", 32'(stallCycles), 32'd2);

        applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("branch_over_lu", 32'(ctrlVec()), 32'(C_BR));
        stepCycle();
        checkOutput("branch_count", 32'(stallCycles), 32'd2);

        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("mem_ready_same_cycle", 32'(ctrlVec()), 32'(C_NONE));
        stepCycle();

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("memwait_%0d", i), 32'(ctrlVec()), 32'(C_MW));
            stepCycle();
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("memwait_release", 32'(ctrlVec()), 32'(C_NONE));
        stepCycle();
        checkOutput("memwait_count", 32'(stallCycles), 32'd5);
        applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("memwait_back_in_run", 32'(ctrlVec()), 32'(C_LU));
        stepCycle();

        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("branch_held_%0d", i), 32'(ctrlVec()), 32'(C_MW));
            stepCycle();
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("branch_after_release", 32'(ctrlVec()), 32'(C_BR));
        stepCycle();
        checkOutput("branch_held_count", 32'(stallCycles), 32'd8);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("watchdog_wait_%0d", i), 32'(ctrlVec()), 32'(C_MW));
            stepCycle();
        end
        checkOutput("watchdog_halt", 32'(ctrlVec()), 32'(C_HALT));
        checkOutput("watchdog_count", 32'(stallCycles), 32'd13);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("halt_ignores_inputs", 32'(ctrlVec()), 32'(C_HALT));
        stepCycle();
        checkOutput("halt_count", 32'(stallCycles), 32'd15);

        rst = 1'b0;
        #1;
        checkOutput("halt_reset_ctrl", 32'(ctrlVec()), 32'(C_NONE));
        checkOutput("halt_reset_count", 32'(stallCycles), 32'd0);
        stepCycle();
        rst = 1'b1;
        applyIdle();
        checkOutput("after_reset_run", 32'(ctrlVec()), 32'(C_NONE));
        stepCycle();

        applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (65534) stepCycle();
        checkOutput("sat_below", 32'(stallCycles), 32'hFFFE);
        stepCycle();
        checkOutput("sat_reach", 32'(stallCycles), 32'hFFFF);
        repeat (5) stepCycle();
        checkOutput("sat_hold", 32'(stallCycles), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
